wgt_rf_ctrl: RTL and testbench

Sequencer for the bank of NUM_FILTERS weight shift register files (one per filter column) in the systolic array. On start it fetches BUFFER_SIZE weight words (each word carries one weight per filter) from weight SRAM and shifts them into all RFs in parallel with select_wgt=1. It then recirculates the RFs (select_wgt=0) for num_pass full passes, one per output tile, and raises done when finished. It honours a stall from the activation feeder and drives a valid/index tag aligned with the RF outputs.

---
 rtl/wgt_rf_ctrl_pkg.sv | 7 +
 rtl/wgt_rf_ctrl_if.sv | 30 +++
 rtl/wgt_rf_ctrl_mod_cnt.sv | 20 ++
 rtl/wgt_rf_ctrl.sv | 81 ++++++++
 tb/tb_wgt_rf_ctrl.sv | 113 +++++++++++
 5 files changed

// File: rtl/wgt_rf_ctrl_pkg.sv
// wgt_rf_ctrl_pkg: shared state encoding and default sizes for the weight RF sequencer
package wgt_ctrl_pkg;
  localparam int DEF_BUFFER_SIZE = 27;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_PASS_W = 12;
  typedef enum logic [2:0] {IDLE, LOAD, LOAD_TAIL, COMPUTE, DONE} state_e;
endpackage

// File: rtl/wgt_rf_ctrl_if.sv
// wgt_rf_ctrl_if: command, SRAM read and RF control bundle of the weight sequencer
interface wgt_rf_ctrl_if
  import wgt_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PASS_W = DEF_PASS_W,
  parameter int CNT_W = $clog2(DEF_BUFFER_SIZE)
);
  logic start;
  logic [ADDR_W-1:0] wgt_base_addr;
  logic [PASS_W-1:0] num_pass;
  logic stall;
  logic wgt_rd_en;
  logic [ADDR_W-1:0] wgt_rd_addr;
  logic select_wgt;
  logic wgt_RF_shift_en;
  logic wgt_out_valid;
  logic [CNT_W-1:0] k_idx;
  logic pass_last;
  logic busy;
  logic done;
  modport master(
    output start, wgt_base_addr, num_pass, stall,
    input wgt_rd_en, wgt_rd_addr, select_wgt, wgt_RF_shift_en, wgt_out_valid, k_idx, pass_last, busy, done
  );
  modport slave(
    input start, wgt_base_addr, num_pass, stall,
    output wgt_rd_en, wgt_rd_addr, select_wgt, wgt_RF_shift_en, wgt_out_valid, k_idx, pass_last, busy, done
  );
endinterface

// File: rtl/wgt_rf_ctrl_mod_cnt.sv
// mod_cnt: counter that wraps to zero after reaching a runtime limit and flags that limit
module mod_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  logic [W-1:0] cnt_d, cnt_q;
  assign wrap = cnt_q == last;
  assign cnt = cnt_q;
  always_comb cnt_d = clr ? '0 : en ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/wgt_rf_ctrl.sv
// wgt_rf_ctrl: loads weight words from SRAM into the filter RFs, then recirculates them once per pass
module wgt_rf_ctrl
  import wgt_ctrl_pkg::*;
#(
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PASS_W = DEF_PASS_W
) (
  input logic clk,
  input logic rst_n,
  wgt_rf_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(BUFFER_SIZE);
  state_e state_d, state_q;
  logic [CNT_W-1:0] k;
  logic [PASS_W-1:0] pass;
  logic k_wrap, pass_wrap, start_acc, load, cs;
  logic rd_en_d, rd_en_q, ld_shift_q, valid_d, valid_q, pass_last_d, pass_last_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [PASS_W-1:0] np_d, np_q;
  logic [CNT_W-1:0] k_idx_d, k_idx_q;
  assign start_acc = state_q == IDLE && bus.start;
  assign load = state_q == LOAD;
  assign cs = state_q == COMPUTE && !bus.stall;
  mod_cnt #(.W(CNT_W)) u_k_cnt (
    .clk(clk), .rst_n(rst_n), .clr(start_acc), .en(load || cs),
    .last(CNT_W'(BUFFER_SIZE - 1)), .cnt(k), .wrap(k_wrap)
  );
  mod_cnt #(.W(PASS_W)) u_pass_cnt (
    .clk(clk), .rst_n(rst_n), .clr(start_acc), .en(cs && k_wrap),
    .last(np_q - 1'b1), .cnt(pass), .wrap(pass_wrap)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.start) state_d = LOAD;
      LOAD:      if (k_wrap) state_d = LOAD_TAIL;
      LOAD_TAIL: state_d = np_q == '0 ? DONE : COMPUTE;
      COMPUTE:   if (cs && k_wrap && pass_wrap) state_d = DONE;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    rd_en_d = start_acc || (load && !k_wrap);
    addr_d = start_acc ? bus.wgt_base_addr : (load && !k_wrap) ? addr_q + 1'b1 : addr_q;
    np_d = start_acc ? bus.num_pass : np_q;
    valid_d = cs;
    k_idx_d = k;
    pass_last_d = pass_wrap;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      ld_shift_q <= 1'b0;
      addr_q <= '0;
      np_q <= '0;
      valid_q <= 1'b0;
      k_idx_q <= '0;
      pass_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      ld_shift_q <= rd_en_q;
      addr_q <= addr_d;
      np_q <= np_d;
      valid_q <= valid_d;
      k_idx_q <= k_idx_d;
      pass_last_q <= pass_last_d;
    end
  // SRAM data lands one cycle after the read, so the load shift trails rd_en by a flop
  assign bus.wgt_rd_en = rd_en_q;
  assign bus.wgt_rd_addr = addr_q;
  assign bus.select_wgt = ld_shift_q;
  assign bus.wgt_RF_shift_en = ld_shift_q || cs;
  assign bus.wgt_out_valid = valid_q;
  assign bus.k_idx = k_idx_q;
  assign bus.pass_last = pass_last_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
endmodule

// File: tb/tb_wgt_rf_ctrl.sv
// tb_wgt_rf_ctrl: directed checks of the weight sequencer against an SRAM and RF bank model
module tb_wgt_rf_ctrl;
  logic clk, rst_n;
  int n_cmp = 0, n_err = 0;
  wgt_rf_ctrl_if #(.ADDR_W(10), .PASS_W(12), .CNT_W(2)) bus ();
  wgt_rf_ctrl #(.BUFFER_SIZE(4), .ADDR_W(10), .PASS_W(12)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] sram_q, rf_out;
  logic [7:0] rf [4];
  function automatic logic [7:0] wdat(input logic [9:0] a);
    return 8'(a * 7 + 8'h35);
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sram_q <= '0;
      rf_out <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      if (bus.wgt_rd_en) sram_q <= wdat(bus.wgt_rd_addr);
      if (bus.wgt_RF_shift_en) begin
        rf_out <= rf[3];
        rf[0] <= bus.select_wgt ? sram_q : rf[3];
        for (int i = 1; i < 4; i++) rf[i] <= rf[i-1];
      end
    end
  function automatic logic [5:0] st();
    return {bus.busy, bus.done, bus.wgt_rd_en, bus.select_wgt, bus.wgt_RF_shift_en, bus.wgt_out_valid};
  endfunction
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic run(input logic [9:0] base, input int np, input int st_lo, input int st_hi,
                     input int spur, input int ncyc);
    int n = 0, pn = 0;
    bit ps = 0, fin = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.wgt_base_addr = base;
    bus.num_pass = 12'(np);
    @(posedge clk);
    #1;
    bus.wgt_base_addr = ~base;
    bus.num_pass = 12'(np + 5);
    for (int c = 1; c <= ncyc; c++) begin
      bit ld, cs, dn, stl;
      stl = c >= st_lo && c <= st_hi;
      bus.start = c == spur;
      bus.stall = stl;
      @(negedge clk);
      ld = c >= 2 && c <= 5;
      cs = np > 0 && c >= 6 && n < 4 * np && !stl;
      dn = np == 0 ? c == 6 : ps && pn == 4 * np - 1;
      chk($sformatf("c%0d ctl", c), 32'(st()), 32'({!fin, dn, c <= 4, ld, ld | cs, ps}));
      if (c <= 4) chk($sformatf("c%0d addr", c), 32'(bus.wgt_rd_addr), 32'(10'(base + 10'(c - 1))));
      if (ps) begin
        chk($sformatf("c%0d k_idx", c), 32'(bus.k_idx), 32'(pn % 4));
        chk($sformatf("c%0d pass_last", c), 32'(bus.pass_last), 32'(pn / 4 == np - 1));
        chk($sformatf("c%0d rf_out", c), 32'(rf_out), 32'(wdat(10'(base + 10'(pn % 4)))));
      end
      if (dn) fin = 1;
      ps = cs;
      if (cs) begin
        pn = n;
        n++;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.wgt_base_addr = '0;
    bus.num_pass = '0;
    repeat (2) @(negedge clk);
    chk("rst ctl", 32'(st()), 32'd0);
    chk("rst addr", 32'(bus.wgt_rd_addr), 32'd0);
    chk("rst tag", 32'({bus.k_idx, bus.pass_last}), 32'd0);
    rst_n = 1'b1;
    run(10'h010, 2, 99, 0, 0, 16);
    run(10'h010, 2, 8, 9, 0, 18);
    run(10'h010, 0, 99, 0, 0, 8);
    run(10'h3FE, 1, 99, 0, 3, 12);
    run(10'h010, 2, 99, 0, 0, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst ctl", 32'(st()), 32'd0);
    chk("arst addr", 32'(bus.wgt_rd_addr), 32'd0);
    chk("arst tag", 32'({bus.k_idx, bus.pass_last}), 32'd0);
    @(negedge clk);
    chk("arst hold", 32'(st()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post rst", 32'(st()), 32'd0);
    run(10'h010, 2, 99, 0, 0, 16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
